alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Owns the PC and the instruction fetch handshake, and builds the 12-bit `operation` code for the registered ALU.
- Sequences fetch, decode, execute, memory and writeback, and decides branches from the ALU `zero` flag.
- Sits between the instruction register, regfile, ALU and data-memory port.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- instr  in  32  instruction register contents; valid from DECODE onward.
- imm  in  XLEN  sign-extended immediate from the decoder.
- rs1_val  in  XLEN  regfile rs1 read data (JALR target).
- zero  in  1  ALU branch condition.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  fetch request; address = pc.
- ir_load  out  1  load instruction register this cycle.
- pc  out  XLEN  current PC.
- operation  out  12  ALU operation code.
- opr2_sel  out  1  0 = rs2, 1 = imm.
- dmem_req  out  1  data access request; address = ALU result.
- dmem_we  out  1  store when 1.
- rf_we  out  1  regfile write enable.
- wb_sel  out  1  0 = ALU result, 1 = load data.
- illegal  out  1  unsupported opcode flag.
- state  out  3  FSM state, for debug.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=FETCH, pc=RESET_PC.
  - imem_req, ir_load, dmem_req, dmem_we, rf_we, wb_sel, illegal, opr2_sel all 0; operation=0.
  - Reset wins over every other event, including mid-access. An outstanding imem/dmem request drops the next cycle.
- State encoding: FETCH=0, DECODE=1, EXEC=2, RESULT=3, MEM=4, WB=5, HALT=6.
- FETCH:
  - imem_req=1, held until imem_ready.
  - On imem_ready: ir_load=1 in the same cycle, then go to DECODE.
  - imem_ready outside FETCH is ignored.
- DECODE: one cycle; `operation` and `opr2_sel` become valid; go to EXEC.
- EXEC: one cycle; the ALU registers its result at the end of this cycle; go to RESULT.
- `operation` encoding. It is held stable from DECODE until the instruction leaves WB, RESULT or MEM, so the ALU result stays stable.
  - OP (0110011): {instr[30], 0, funct3, opcode}.
  - OP-IMM with funct3=101: {0, instr[30], funct3, opcode}.
  - Loads, stores, branches, JALR, other OP-IMM: {00, funct3, opcode}.
  - JAL, LUI, AUIPC: {00, 000, opcode}.
- `opr2_sel`: 1 for OP-IMM, load, store, LUI, AUIPC; otherwise 0.
- RESULT, by instruction class:
  - OP, OP-IMM, LUI, AUIPC: rf_we=1 (wb_sel=0), pc <= pc+4, go to FETCH.
  - JAL: rf_we=1 (ALU supplies pc+4), pc <= pc+imm.
  - JALR: rf_we=1, pc <= (rs1_val+imm) & ~1.
  - Branch: no write; pc <= zero ? pc+imm : pc+4.
  - Load/store: go to MEM, no PC change.
- rf_we is forced to 0 whenever instr[11:7]==0 (writes to x0 are suppressed).
- MEM:
  - dmem_req=1; dmem_we=1 for stores. Both held until dmem_ready.
  - Store: on dmem_ready, pc <= pc+4, go to FETCH.
  - Load: on dmem_ready, go to WB.
- WB (load only): rf_we=1, wb_sel=1, pc <= pc+4, go to FETCH.
- PC arithmetic is modulo 2^XLEN (wraps silently); misaligned targets are not checked.
- Latency with zero-wait memories:
  - ALU / jump / branch: 4 cycles per instruction.
  - Store: 5 cycles.
  - Load: 6 cycles.
  - Each memory wait cycle adds one cycle.
- rf_we and dmem_req are single-cycle pulses, except dmem_req, which stays high while waiting for dmem_ready.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Unsupported opcode (anything outside OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC):
  - Defined: in DECODE go to HALT. illegal=1 (sticky), pc frozen, all requests 0; leave HALT only on rst.
  - Undefined: treated as a NOP. operation=0, no write, pc <= pc+4 in RESULT; illegal tied to 0 and HALT unreachable.

Test Plan:
- Reset, then `addi x1,x0,5` (0x00500093) with imem_ready=1: FETCH→DECODE→EXEC→RESULT.
  - operation=12'b000000010011, opr2_sel=1.
  - rf_we pulse in cycle 4; pc 0→4; next imem_req in cycle 5.
- `sub x3,x1,x2` (0x402081B3): operation=12'b100000110011; `srai x5,x1,2` (0x4020D293): operation=12'b011010010011.
- `beq` with imm=16 at pc=8:
  - zero=1 → pc=24.
  - zero=0 → pc=12.
  - rf_we stays 0 in both cases.
- `lw` with dmem_ready held low 3 cycles: dmem_req=1 for 4 cycles with dmem_we=0, then WB with rf_we=1, wb_sel=1; total 9 cycles. `sw`: dmem_we=1, no rf_we.
- `jalr x0,0(x1)` with rs1_val=0x103: pc=0x102, rf_we=0 (rd=x0). `jal x1,-8` at pc=0x20: pc=0x18, rf_we=1.
- rst asserted during MEM with dmem_req high: next cycle dmem_req=0, state=FETCH, pc=RESET_PC. With ILLEGAL_TRAP_EN, fetching 0xFFFFFFFF gives illegal=1, state=6, imem_req held 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the RV32I core.
// Owns the PC and the fetch handshake, builds the 12-bit ALU operation code,
// and sequences FETCH -> DECODE -> EXEC -> RESULT [-> MEM [-> WB]] -> FETCH.
// Optional build macro: ILLEGAL_TRAP_EN
//   defined   : an unsupported opcode halts the core in HALT with illegal=1.
//   undefined : an unsupported opcode executes as a NOP; illegal is tied to 0.
module alu_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            zero,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            imem_req,
    output logic            ir_load,
    output logic [XLEN-1:0] pc,
    output logic [11:0]     operation,
    output logic            opr2_sel,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            rf_we,
    output logic            wb_sel,
    output logic            illegal,
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_RESULT = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_OP,
        C_OPIMM,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC,
        C_ILLEGAL
    } iclass_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    iclass_t         iclass;
    logic [11:0]     op_dec;
    logic            sel_dec;
    logic            rf_we_raw;
    logic            decoded_phase;
    logic            rd_nonzero;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_target;
    logic            unused_instr_bits;

    wire [6:0] opcode = instr[6:0];
    wire [2:0] funct3 = instr[14:12];

    // Register/immediate fields beyond funct3/rd/bit 30 belong to the datapath.
    assign unused_instr_bits = ^{instr[31], instr[29:15]};

    assign rd_nonzero  = (instr[11:7] != 5'd0);
    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc_plus_imm = pc_q + imm;
    assign jalr_target = (rs1_val + imm) & ~XLEN'(1);

    // Classify the instruction held in the instruction register.
    always_comb begin
        iclass = C_ILLEGAL;
        case (opcode)
            OPC_OP:     iclass = C_OP;
            OPC_OPIMM:  iclass = C_OPIMM;
            OPC_LOAD:   iclass = C_LOAD;
            OPC_STORE:  iclass = C_STORE;
            OPC_BRANCH: iclass = C_BRANCH;
            OPC_JAL:    iclass = C_JAL;
            OPC_JALR:   iclass = C_JALR;
            OPC_LUI:    iclass = C_LUI;
            OPC_AUIPC:  iclass = C_AUIPC;
            default:    iclass = C_ILLEGAL;
        endcase
    end

    // Build the ALU operation code and operand-2 select for the current class.
    always_comb begin
        op_dec  = '0;
        sel_dec = 1'b0;
        case (iclass)
            C_OP: op_dec = {instr[30], 1'b0, funct3, opcode};
            C_OPIMM: begin
                sel_dec = 1'b1;
                // Only the shift-right immediates use bit 30 (SRLI vs SRAI).
                if (funct3 == 3'b101) op_dec = {1'b0, instr[30], funct3, opcode};
                else                  op_dec = {2'b00, funct3, opcode};
            end
            C_LOAD, C_STORE: begin
                sel_dec = 1'b1;
                op_dec  = {2'b00, funct3, opcode};
            end
            C_BRANCH, C_JALR: op_dec = {2'b00, funct3, opcode};
            C_JAL:            op_dec = {5'b00000, opcode};
            C_LUI, C_AUIPC: begin
                sel_dec = 1'b1;
                op_dec  = {5'b00000, opcode};
            end
            default: begin
                op_dec  = '0;
                sel_dec = 1'b0;
            end
        endcase
    end

    // The IR is stable from DECODE until the next fetch, so the decoded code
    // stays constant through EXEC/RESULT/MEM/WB and the ALU result holds.
    assign decoded_phase = state_q inside {S_DECODE, S_EXEC, S_RESULT, S_MEM, S_WB};
    assign operation     = (decoded_phase && !rst) ? op_dec : 12'd0;
    assign opr2_sel      = decoded_phase && !rst && sel_dec;

    // Next-state, next-PC and per-state handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        pc_d      = pc_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we_raw = 1'b0;
        wb_sel    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
                if (iclass == C_ILLEGAL) state_d = S_HALT;
`endif
            end
            S_EXEC: state_d = S_RESULT;
            S_RESULT: begin
                state_d = S_FETCH;
                pc_d    = pc_plus4;
                case (iclass)
                    C_OP, C_OPIMM, C_LUI, C_AUIPC: rf_we_raw = 1'b1;
                    C_JAL: begin
                        rf_we_raw = 1'b1;
                        pc_d      = pc_plus_imm;
                    end
                    C_JALR: begin
                        rf_we_raw = 1'b1;
                        pc_d      = jalr_target;
                    end
                    C_BRANCH: pc_d = zero ? pc_plus_imm : pc_plus4;
                    C_LOAD, C_STORE: begin
                        pc_d    = pc_q;
                        state_d = S_MEM;
                    end
                    default: begin
                        // Unsupported opcode without the trap: plain NOP.
                        rf_we_raw = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == C_STORE);
                if (dmem_ready) begin
                    if (iclass == C_STORE) begin
                        pc_d    = pc_plus4;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_raw = 1'b1;
                wb_sel    = 1'b1;
                pc_d      = pc_plus4;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        // While reset is asserted every request is withdrawn immediately.
        if (rst) begin
            imem_req  = 1'b0;
            ir_load   = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            rf_we_raw = 1'b0;
            wb_sel    = 1'b0;
        end
    end

    // Writes to x0 are suppressed here so the regfile never sees them.
    assign rf_we = rf_we_raw && rd_nonzero;

    // State and PC registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc    = pc_q;
    assign state = state_q;

`ifdef ILLEGAL_TRAP_EN
    // HALT is only ever entered on an illegal opcode and only left by reset,
    // so the state itself is the sticky flag.
    assign illegal = (state_q == S_HALT) && !rst;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed testbench for alu_sequencer with hand-computed expected values.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [31:0] rs1_val;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_load;
    logic [31:0] pc;
    logic [11:0] operation;
    logic        opr2_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        wb_sel;
    logic        illegal;
    logic [2:0]  state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc;

    localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_SUB   = 32'h4020_81B3; // sub  x3,x1,x2
    localparam logic [31:0] I_SRAI  = 32'h4020_D293; // srai x5,x1,2
    localparam logic [31:0] I_BEQ   = 32'h0000_0863; // beq  x0,x0,16
    localparam logic [31:0] I_LW    = 32'h0000_2303; // lw   x6,0(x0)
    localparam logic [31:0] I_SW    = 32'h0060_2023; // sw   x6,0(x0)
    localparam logic [31:0] I_JALR  = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] I_JAL   = 32'hFF9F_F0EF; // jal  x1,-8
    localparam logic [31:0] I_BAD   = 32'hFFFF_FFFF;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .imm        (imm),
        .rs1_val    (rs1_val),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_load    (ir_load),
        .pc         (pc),
        .operation  (operation),
        .opr2_sel   (opr2_sel),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .rf_we      (rf_we),
        .wb_sel     (wb_sel),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present an instruction in FETCH with imem_ready=1; returns in DECODE.
    task automatic run_fetch(input logic [31:0] ins, input logic [31:0] im);
        instr      = ins;
        imm        = im;
        imem_ready = 1'b1;
        cyc        = 0;
        step();
        imem_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h0; imm = 32'h0; rs1_val = 32'h0;
        zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        step(); step();
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h expected 0", pc); end
        vectors++; if ({imem_req, ir_load, dmem_req, dmem_we, rf_we, wb_sel, illegal, opr2_sel} !== 8'h00) begin
            miscompares++; $display("FAIL reset_outputs: got %b expected 00000000",
                {imem_req, ir_load, dmem_req, dmem_we, rf_we, wb_sel, illegal, opr2_sel}); end
        vectors++; if (operation !== 12'h000) begin miscompares++; $display("FAIL reset_operation: got %h expected 000", operation); end
        rst = 1'b0;
        #1;
        // imem_req must be held while imem_ready stays low.
        step(); step();
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL fetch_wait_state: got %0d expected 0", state); end
        vectors++; if (imem_req !== 1'b1 || ir_load !== 1'b0) begin miscompares++; $display("FAIL fetch_wait_req: got req=%b load=%b expected req=1 load=0", imem_req, ir_load); end
    endtask

    task automatic test_addi();
        instr = I_ADDI; imm = 32'd5; imem_ready = 1'b1;
        #1;
        vectors++; if (ir_load !== 1'b1) begin miscompares++; $display("FAIL addi_ir_load: got %b expected 1", ir_load); end
        step();
        imem_ready = 1'b1; // ignored outside FETCH
        #1;
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL addi_decode_state: got %0d expected 1", state); end
        vectors++; if (operation !== 12'b000000010011) begin miscompares++; $display("FAIL addi_operation: got %b expected 000000010011", operation); end
        vectors++; if (opr2_sel !== 1'b1) begin miscompares++; $display("FAIL addi_opr2_sel: got %b expected 1", opr2_sel); end
        vectors++; if (imem_req !== 1'b0 || ir_load !== 1'b0) begin miscompares++; $display("FAIL addi_decode_noreq: got req=%b load=%b expected 0 0", imem_req, ir_load); end
        imem_ready = 1'b0;
        step();
        vectors++; if (state !== 3'd2 || operation !== 12'h013) begin miscompares++; $display("FAIL addi_exec: got state=%0d op=%h expected 2 013", state, operation); end
        step();
        vectors++; if (state !== 3'd3 || rf_we !== 1'b1 || wb_sel !== 1'b0) begin miscompares++; $display("FAIL addi_result: got state=%0d we=%b wb=%b expected 3 1 0", state, rf_we, wb_sel); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL addi_pc_hold: got %h expected 0", pc); end
        step();
        vectors++; if (pc !== 32'h4 || state !== 3'd0 || imem_req !== 1'b1 || rf_we !== 1'b0) begin
            miscompares++; $display("FAIL addi_next_fetch: got pc=%h state=%0d req=%b we=%b expected 4 0 1 0", pc, state, imem_req, rf_we); end
    endtask

    task automatic test_op_encoding(input logic [31:0] ins, input logic [11:0] exp_op,
                                    input logic exp_sel, input logic [31:0] exp_pc);
        run_fetch(ins, 32'd2);
        vectors++; if (operation !== exp_op || opr2_sel !== exp_sel) begin
            miscompares++; $display("FAIL op_encoding_%h: got op=%b sel=%b expected op=%b sel=%b", ins, operation, opr2_sel, exp_op, exp_sel); end
        step(); step();
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL op_rf_we_%h: got %b expected 1", ins, rf_we); end
        step();
        vectors++; if (pc !== exp_pc || cyc !== 4) begin miscompares++; $display("FAIL op_pc_%h: got pc=%h cycles=%0d expected %h 4", ins, pc, cyc, exp_pc); end
    endtask

    task automatic test_branch(input logic z, input logic [31:0] exp_pc);
        zero = z;
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL branch_start_pc: got %h expected 8", pc); end
        run_fetch(I_BEQ, 32'd16);
        vectors++; if (operation !== 12'h063 || opr2_sel !== 1'b0) begin miscompares++; $display("FAIL branch_operation: got op=%h sel=%b expected 063 0", operation, opr2_sel); end
        step(); step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL branch_rf_we_z%0b: got %b expected 0", z, rf_we); end
        step();
        vectors++; if (pc !== exp_pc) begin miscompares++; $display("FAIL branch_pc_z%0b: got %h expected %h", z, pc, exp_pc); end
        zero = 1'b0;
    endtask

    task automatic test_load_wait();
        run_fetch(I_LW, 32'd0);
        vectors++; if (operation !== 12'h103 || opr2_sel !== 1'b1) begin miscompares++; $display("FAIL lw_operation: got op=%h sel=%b expected 103 1", operation, opr2_sel); end
        step(); step();
        vectors++; if (rf_we !== 1'b0 || dmem_req !== 1'b0) begin miscompares++; $display("FAIL lw_result: got we=%b req=%b expected 0 0", rf_we, dmem_req); end
        dmem_ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (state !== 3'd4 || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
                miscompares++; $display("FAIL lw_mem_cycle%0d: got state=%0d req=%b we=%b expected 4 1 0", i, state, dmem_req, dmem_we); end
            if (i == 3) dmem_ready = 1'b1;
            step();
        end
        dmem_ready = 1'b0;
        vectors++; if (state !== 3'd5 || rf_we !== 1'b1 || wb_sel !== 1'b1 || dmem_req !== 1'b0) begin
            miscompares++; $display("FAIL lw_wb: got state=%0d we=%b wb=%b req=%b expected 5 1 1 0", state, rf_we, wb_sel, dmem_req); end
        step();
        vectors++; if (pc !== 32'd16 || state !== 3'd0 || cyc !== 9) begin
            miscompares++; $display("FAIL lw_done: got pc=%h state=%0d cycles=%0d expected 10 0 9", pc, state, cyc); end
    endtask

    task automatic test_store();
        run_fetch(I_SW, 32'd0);
        vectors++; if (operation !== 12'h123 || opr2_sel !== 1'b1) begin miscompares++; $display("FAIL sw_operation: got op=%h sel=%b expected 123 1", operation, opr2_sel); end
        step(); step(); step();
        vectors++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || rf_we !== 1'b0) begin
            miscompares++; $display("FAIL sw_mem: got req=%b we=%b rf_we=%b expected 1 1 0", dmem_req, dmem_we, rf_we); end
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        vectors++; if (pc !== 32'd20 || state !== 3'd0 || cyc !== 5 || dmem_req !== 1'b0) begin
            miscompares++; $display("FAIL sw_done: got pc=%h state=%0d cycles=%0d req=%b expected 14 0 5 0", pc, state, cyc, dmem_req); end
    endtask

    task automatic test_jumps();
        rs1_val = 32'h103;
        run_fetch(I_JALR, 32'd0);
        vectors++; if (operation !== 12'h067 || opr2_sel !== 1'b0) begin miscompares++; $display("FAIL jalr_operation: got op=%h sel=%b expected 067 0", operation, opr2_sel); end
        step(); step();
        vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL jalr_x0_rf_we: got %b expected 0", rf_we); end
        step();
        vectors++; if (pc !== 32'h102) begin miscompares++; $display("FAIL jalr_pc: got %h expected 102", pc); end
        // PC wraps modulo 2^32.
        rs1_val = 32'hFFFF_FFFF;
        run_fetch(I_JALR, 32'd0);
        step(); step(); step();
        vectors++; if (pc !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL jalr_wrap_target: got %h expected fffffffe", pc); end
        run_fetch(I_ADDI, 32'd5);
        step(); step(); step();
        vectors++; if (pc !== 32'h2) begin miscompares++; $display("FAIL pc_wrap: got %h expected 2", pc); end
        rs1_val = 32'h20;
        run_fetch(I_JALR, 32'd0);
        step(); step(); step();
        vectors++; if (pc !== 32'h20) begin miscompares++; $display("FAIL jalr_to_20: got %h expected 20", pc); end
        run_fetch(I_JAL, 32'hFFFF_FFF8);
        vectors++; if (operation !== 12'h06F || opr2_sel !== 1'b0) begin miscompares++; $display("FAIL jal_operation: got op=%h sel=%b expected 06f 0", operation, opr2_sel); end
        step(); step();
        vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL jal_rf_we: got %b expected 1", rf_we); end
        step();
        vectors++; if (pc !== 32'h18) begin miscompares++; $display("FAIL jal_pc: got %h expected 18", pc); end
    endtask

    task automatic test_reset_mid_mem();
        dmem_ready = 1'b0;
        run_fetch(I_LW, 32'd0);
        step(); step(); step();
        vectors++; if (dmem_req !== 1'b1 || state !== 3'd4) begin miscompares++; $display("FAIL rstmem_setup: got req=%b state=%0d expected 1 4", dmem_req, state); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vectors++; if (dmem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0) begin
            miscompares++; $display("FAIL rstmem_after: got req=%b state=%0d pc=%h expected 0 0 0", dmem_req, state, pc); end
        step();
        vectors++; if (dmem_req !== 1'b0 || state !== 3'd0 || imem_req !== 1'b1) begin
            miscompares++; $display("FAIL rstmem_settled: got dreq=%b state=%0d ireq=%b expected 0 0 1", dmem_req, state, imem_req); end
    endtask

    task automatic test_illegal();
        run_fetch(I_BAD, 32'd0);
`ifdef ILLEGAL_TRAP_EN
        step();
        imem_ready = 1'b1;
        vectors++; if (state !== 3'd6 || illegal !== 1'b1) begin miscompares++; $display("FAIL trap_enter: got state=%0d illegal=%b expected 6 1", state, illegal); end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (state !== 3'd6 || illegal !== 1'b1 || imem_req !== 1'b0 || ir_load !== 1'b0 || pc !== 32'h0 || rf_we !== 1'b0) begin
                miscompares++; $display("FAIL trap_hold%0d: got state=%0d ill=%b req=%b load=%b pc=%h we=%b expected 6 1 0 0 0 0",
                    i, state, illegal, imem_req, ir_load, pc, rf_we); end
        end
        imem_ready = 1'b0;
        do_reset();
        vectors++; if (state !== 3'd0 || illegal !== 1'b0) begin miscompares++; $display("FAIL trap_cleared: got state=%0d illegal=%b expected 0 0", state, illegal); end
`else
        vectors++; if (operation !== 12'h000 || opr2_sel !== 1'b0) begin miscompares++; $display("FAIL nop_operation: got op=%h sel=%b expected 000 0", operation, opr2_sel); end
        step(); step();
        vectors++; if (rf_we !== 1'b0 || illegal !== 1'b0 || state !== 3'd3) begin
            miscompares++; $display("FAIL nop_result: got we=%b illegal=%b state=%0d expected 0 0 3", rf_we, illegal, state); end
        step();
        vectors++; if (pc !== 32'h4 || state !== 3'd0) begin miscompares++; $display("FAIL nop_pc: got pc=%h state=%0d expected 4 0", pc, state); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        cyc = 0;
        test_reset();
        test_addi();
        test_op_encoding(I_SUB, 12'b100000110011, 1'b0, 32'h8);
        test_branch(1'b1, 32'd24);
        do_reset();
        test_op_encoding(I_ADDI, 12'b000000010011, 1'b1, 32'h4);
        test_op_encoding(I_SRAI, 12'b011010010011, 1'b1, 32'h8);
        test_branch(1'b0, 32'd12);
        test_load_wait();
        test_store();
        test_jumps();
        test_reset_mid_mem();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
